// File: rtl/muldiv_pkg.sv
// Shared encodings and defaults for the iterative multiply/divide unit.
package muldiv_pkg;

    localparam int unsigned WIDTH_DEF = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10
    } state_t;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// One shift-add or restoring-divide step per cycle on unsigned magnitudes, sign fixed at the end.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = $clog2(WIDTH);

    state_t             state, state_next;
    logic               is_div;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   bmag;
    logic               neg_q;
    logic               neg_r;
    logic [CW-1:0]      count;

    // Operand decode at acceptance time
    logic             op_is_div, op_signed, a_neg, b_neg;
    logic [WIDTH-1:0] amag, bmag_in;

    assign op_is_div = (op == OP_DIV) || (op == OP_DIVU);
    assign op_signed = (op == OP_MULT) || (op == OP_DIV);
    assign a_neg     = op_signed & a[WIDTH-1];
    assign b_neg     = op_signed & b[WIDTH-1];
    assign amag      = a_neg ? ('0 - a) : a;
    assign bmag_in   = b_neg ? ('0 - b) : b;

    // One iteration of each algorithm
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_step;
    logic [WIDTH:0]     rem_shift, rem_diff;
    logic               qbit;
    logic [2*WIDTH-1:0] div_step;

    assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? bmag : '0)};
    assign mul_step  = {mul_sum, acc[WIDTH-1:1]};
    assign rem_shift = acc[2*WIDTH-1:WIDTH-1];
    assign rem_diff  = rem_shift - {1'b0, bmag};
    assign qbit      = ~rem_diff[WIDTH];
    assign div_step  = {(qbit ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0]), acc[WIDTH-2:0], qbit};

    // Sign correction; a zero divisor leaves the dividend as remainder and forces LO to all ones
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem, res_hi, res_lo;
    logic               bzero;

    assign bzero  = (bmag == '0);
    assign prod   = neg_q ? ('0 - acc) : acc;
    assign quo    = neg_q ? ('0 - acc[WIDTH-1:0]) : acc[WIDTH-1:0];
    assign rem    = neg_r ? ('0 - acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];
    assign res_hi = is_div ? rem : prod[2*WIDTH-1:WIDTH];
    assign res_lo = is_div ? (bzero ? '1 : quo) : prod[WIDTH-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (count == '0) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            is_div <= 1'b0;
            acc    <= '0;
            bmag   <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            count  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            div0   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            busy <= (state_next != IDLE);
            done <= (state == FIX);
            case (state)
                IDLE: begin
                    if (start) begin
                        is_div <= op_is_div;
                        acc    <= {{WIDTH{1'b0}}, amag};
                        bmag   <= bmag_in;
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        count  <= CW'(WIDTH - 1);
                        div0   <= 1'b0;
                    end else begin
                        if (mthi) hi <= wdata;
                        if (mtlo) lo <= wdata;
                    end
                end
                RUN: begin
                    acc <= is_div ? div_step : mul_step;
                    if (count != '0) count <= count - CW'(1);
                end
                FIX: begin
                    hi   <= res_hi;
                    lo   <= res_lo;
                    div0 <= is_div & bzero;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: transaction-level model plus directed literal cases and random traffic.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int unsigned W   = 32;
    localparam int          LAT = 34;

    logic         clk = 1'b0;
    logic         reset;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a = '0, b = '0, wdata = '0;
    logic         mthi = 1'b0, mtlo = 1'b0;
    logic         busy, done, div0;
    logic [W-1:0] hi, lo;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
        .busy(busy), .done(done), .div0(div0), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Architectural result of one operation, straight from integer arithmetic
    function automatic void model_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                     output logic [W-1:0] h, output logic [W-1:0] l, output logic z);
        longint      sx, sy, q, r;
        logic [63:0] p;
        z  = 1'b0;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (o == OP_MULTU) begin
            p = {32'b0, x} * {32'b0, y};
            h = p[63:32]; l = p[31:0];
        end else if (o == OP_MULT) begin
            p = 64'(sx * sy);
            h = p[63:32]; l = p[31:0];
        end else if (y == '0) begin
            h = x; l = '1; z = 1'b1;
        end else if (o == OP_DIVU) begin
            l = x / y; h = x % y;
        end else begin
            q = sx / sy; r = sx % sy;
            l = q[31:0]; h = r[31:0];
        end
    endfunction

    // Transaction-level model of the visible outputs
    logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    logic         m_busy = 1'b0, m_done = 1'b0, m_div0 = 1'b0, p_div0 = 1'b0;
    int           m_left = 0;
    int           n_done = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_hi = '0; m_lo = '0; m_busy = 1'b0; m_done = 1'b0; m_div0 = 1'b0; m_left = 0;
        end else begin
            m_done = 1'b0;
            if (m_left == 0) begin
                if (start) begin
                    model_op(op, a, b, p_hi, p_lo, p_div0);
                    m_div0 = 1'b0;
                    m_busy = 1'b1;
                    m_left = LAT - 1;
                end else begin
                    if (mthi) m_hi = wdata;
                    if (mtlo) m_lo = wdata;
                end
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_hi = p_hi; m_lo = p_lo; m_div0 = p_div0;
                    m_busy = 1'b0; m_done = 1'b1;
                    n_done++;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("model_hi", 64'(hi), 64'(m_hi));
        chk("model_lo", 64'(lo), 64'(m_lo));
        chk("model_flags busy/done/div0", 64'({busy, done, div0}), 64'({m_busy, m_done, m_div0}));
    end

    // Called at #1 after an edge; returns at #1 after the accepting edge
    task automatic kick(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    endtask

    // lat counts edges since the edge before start was driven
    task automatic wait_done(output int lat, output int bcnt);
        lat = 1; bcnt = 0;
        while (!done && lat < 60) begin
            if (busy) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
        chk("done_seen", 64'(done), 64'd1);
    endtask

    function automatic logic [W-1:0] rnd_operand();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int           lat, bcnt, dcount, base;
        logic [W-1:0] th, tl;
        logic         tz;

        reset = 1'b0;
        #1 reset = 1'b1;

        // Pin the model to hand-computed values
        model_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, th, tl, tz);
        chk("pin_mult_lo", 64'(tl), 64'h0000_0000_FFFF_FFEB);
        model_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, th, tl, tz);
        chk("pin_div_hi", 64'(th), 64'h0000_0000_FFFF_FFFF);
        model_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, th, tl, tz);
        chk("pin_ovf_lo", 64'(tl), 64'h0000_0000_8000_0000);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_div0", 64'(div0), 64'd0);
        chk("rst_hi",   64'(hi),   64'd0);
        chk("rst_lo",   64'(lo),   64'd0);
        #2 reset = 1'b0;

        @(posedge clk); #1;
        kick(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(lat, bcnt);
        chk("multu_latency", 64'(lat), 64'(LAT));
        chk("multu_busy_cycles", 64'(bcnt), 64'd33);
        chk("multu_hi", 64'(hi), 64'hFFFF_FFFE);
        chk("multu_lo", 64'(lo), 64'h0000_0001);

        @(posedge clk); #1;
        kick(OP_MULT, 32'hFFFF_FFFD, 32'd7);
        wait_done(lat, bcnt);
        chk("mult_hi", 64'(hi), 64'hFFFF_FFFF);
        chk("mult_lo", 64'(lo), 64'hFFFF_FFEB);

        @(posedge clk); #1;
        kick(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done(lat, bcnt);
        chk("div_lo", 64'(lo), 64'hFFFF_FFFD);
        chk("div_hi", 64'(hi), 64'hFFFF_FFFF);
        kick(OP_DIVU, 32'd7, 32'd2);
        wait_done(lat, bcnt);
        chk("b2b_latency", 64'(lat), 64'(LAT));
        chk("b2b_lo", 64'(lo), 64'd3);
        chk("b2b_hi", 64'(hi), 64'd1);

        @(posedge clk); #1;
        kick(OP_DIV, 32'h1234_5678, 32'd0);
        wait_done(lat, bcnt);
        chk("div0_latency", 64'(lat), 64'(LAT));
        chk("div0_hi", 64'(hi), 64'h1234_5678);
        chk("div0_lo", 64'(lo), 64'hFFFF_FFFF);
        chk("div0_flag", 64'(div0), 64'd1);
        @(posedge clk); #1;
        kick(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div0_cleared_on_start", 64'(div0), 64'd0);
        wait_done(lat, bcnt);
        chk("ovf_lo", 64'(lo), 64'h8000_0000);
        chk("ovf_hi", 64'(hi), 64'd0);
        chk("ovf_div0", 64'(div0), 64'd0);

        // start and mthi during RUN are ignored
        @(posedge clk); #1;
        kick(OP_MULTU, 32'd5, 32'd6);
        repeat (5) @(posedge clk);
        #1;
        start = 1'b1; mthi = 1'b1; wdata = 32'hDEAD_BEEF; op = OP_DIVU; a = 32'd100; b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0; mthi = 1'b0;
        wait_done(lat, bcnt);
        chk("run_ignore_hi", 64'(hi), 64'd0);
        chk("run_ignore_lo", 64'(lo), 64'd30);
        @(posedge clk); #1;
        chk("no_queued_start", 64'(busy), 64'd0);

        mtlo = 1'b1; wdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        mtlo = 1'b0;
        chk("mtlo_idle", 64'(lo), 64'hCAFE_F00D);

        // start wins over a simultaneous mthi
        mthi = 1'b1; wdata = 32'h1111_1111;
        kick(OP_MULTU, 32'd2, 32'd3);
        chk("start_wins_hi_held", 64'(hi), 64'd0);
        chk("start_wins_busy", 64'(busy), 64'd1);
        wait_done(lat, bcnt);
        chk("start_wins_hi", 64'(hi), 64'd0);
        chk("start_wins_lo", 64'(lo), 64'd6);

        // Asynchronous reset in the middle of RUN
        @(posedge clk); #1;
        kick(OP_DIVU, 32'd1000, 32'd7);
        repeat (10) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_hi", 64'(hi), 64'd0);
        chk("arst_lo", 64'(lo), 64'd0);
        @(posedge clk); @(posedge clk);
        #3 reset = 1'b0;
        dcount = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dcount++;
        end
        chk("arst_no_done", 64'(dcount), 64'd0);
        @(posedge clk); #1;
        kick(OP_MULTU, 32'd9, 32'd9);
        wait_done(lat, bcnt);
        chk("arst_fresh_latency", 64'(lat), 64'(LAT));
        chk("arst_fresh_lo", 64'(lo), 64'd81);

        // Random traffic on every input every cycle, checked by the model
        base = n_done;
        repeat (6000) begin
            @(posedge clk); #1;
            start = ($urandom_range(0, 3) == 0);
            op    = 2'($urandom_range(0, 3));
            a     = rnd_operand();
            b     = rnd_operand();
            mthi  = ($urandom_range(0, 3) == 0);
            mtlo  = ($urandom_range(0, 3) == 0);
            wdata = $urandom;
        end
        @(posedge clk); #1;
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        chk("rand_ops_completed", 64'(n_done - base > 100), 64'd1);
        repeat (40) @(posedge clk);
        @(negedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
